led_fade_pwm: RTL and testbench
===============================

Name: led_fade_pwm

Overview:
Downstream stage of the LED blinker. It consumes the blinker's square-wave LED level and drives the physical LED pin. A hard on/off toggle becomes a linear brightness ramp up or down, rendered as PWM. Same clock domain as the blinker; no CDC logic.

Parameters:
PWM_BITS, 8, width of brightness level; MAX = 2^PWM_BITS-1; PWM period = MAX cycles
STEP_CYCLES, 49_000, clk cycles per one-LSB level step (full ramp = MAX*STEP_CYCLES cycles, ~250 ms at 50 MHz)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
blink_in  input  1  target level from blinker: 1 = fade to full, 0 = fade to off
enable  input  1  1 = normal operation; 0 = force dark
pwm_out  output  1  LED drive, registered
level  output  PWM_BITS  current brightness
busy  output  1  1 while ramping (RAMP_UP/RAMP_DOWN)

Behaviour:
- Reset (async assert, sync release): state=IDLE_LOW, level=0, duty=0, pwm_cnt=0, step_cnt=0, pwm_out=0, busy=0.
- States:
  - IDLE_LOW: blink_in=1 -> RAMP_UP.
  - RAMP_UP: blink_in=0 -> RAMP_DOWN. Else if level==MAX -> IDLE_HIGH.
  - IDLE_HIGH: blink_in=0 -> RAMP_DOWN.
  - RAMP_DOWN: blink_in=1 -> RAMP_UP. Else if level==0 -> IDLE_LOW.
- Direction change has priority over the end-of-ramp check. Reversal starts from the current level; there is no jump.
- busy = (state is RAMP_UP or RAMP_DOWN), registered with state. It goes 1 on the same edge that samples the triggering blink_in.
- step_cnt:
  - Cleared on every state transition.
  - In a ramp state it counts 0..STEP_CYCLES-1.
  - On the edge where step_cnt==STEP_CYCLES-1: level +1 (RAMP_UP) or -1 (RAMP_DOWN), and step_cnt returns to 0.
  - First step occurs STEP_CYCLES edges after ramp entry.
  - No increment at MAX, no decrement at 0. Saturating; wrap-around is forbidden.
  - The transition to IDLE_HIGH/IDLE_LOW happens on the edge after level reaches MAX/0.
- PWM:
  - pwm_cnt is free-running, 0..MAX-1, and wraps to 0.
  - duty <= level on the edge where pwm_cnt wraps from MAX-1 to 0, so duty is constant within a period (glitch-free).
  - pwm_out <= enable & (pwm_cnt < duty). One-cycle latency.
  - duty=0 gives constant 0; duty=MAX gives constant 1; duty=k gives exactly k high cycles per MAX-cycle period.
- enable=0:
  - Synchronous override, evaluated every edge: state=IDLE_LOW, level=0, duty=0, step_cnt=0, pwm_out=0, busy=0.
  - pwm_cnt keeps running.
  - After enable returns to 1, normal FSM rules apply (blink_in=1 starts RAMP_UP from 0).
- Simultaneous events:
  - enable=0 outranks everything.
  - Direction change outranks a step on the same edge: counter cleared, no level change.
- Reset mid-ramp: immediate return to reset values; no residual duty.

Test Plan:
(All scenarios use PWM_BITS=4 (MAX=15, period 15) and STEP_CYCLES=4.)
1. Reset mid-ramp:
   - Stimulus: drive blink_in=1; at level=9 assert rst_n=0 between edges.
   - Required: pwm_out, level and busy all read 0 before the next clk edge. They stay 0 until rst_n=1 and blink_in=1.
2. Full ramp up:
   - Stimulus: from idle, blink_in=1 held.
   - Required: busy=1 one edge later; level increments every 4 cycles; level=15 after 60 cycles; IDLE_HIGH and busy=0 one edge later.
   - Required: after the next PWM wrap, pwm_out=1 for all 15 cycles of every period.
3. Reversal:
   - Stimulus: drop blink_in while in RAMP_UP at level=7.
   - Required: busy stays 1; level=6 exactly 4 cycles later; ramps to 0; then IDLE_LOW with pwm_out constantly 0.
4. Duty scoreboard:
   - Stimulus: run repeated full up/down ramps.
   - Required: in every 15-cycle PWM period, the count of pwm_out=1 equals the level sampled at the period start. No level ever exceeds 15 or underflows below 0.
5. enable drop:
   - Stimulus: enable=0 at level=10 during RAMP_UP.
   - Required: next edge gives level=0, busy=0; pwm_out=0 within one cycle.
   - Stimulus: then enable=1 with blink_in=1.
   - Required: ramp restarts from 0 with first increment 4 cycles after RAMP_UP entry.
6. Short pulse:
   - Stimulus: a 1-cycle blink_in=1 pulse from idle.
   - Required: RAMP_UP, then RAMP_DOWN at level 0, then IDLE_LOW. Level never leaves 0; busy high for exactly 2 cycles.

Source files
------------

// File: rtl/led_fade_pwm.sv
// rtl/led_fade_pwm.sv - turns the blinker's on/off level into a linear PWM brightness ramp
module led_fade_pwm #(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 49_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                blink_in,
  input  logic                enable,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] level,
  output logic                busy
);

  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [STEP_W-1:0]   STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [PWM_BITS-1:0] LVL_MAX   = '1;
  localparam logic [PWM_BITS-1:0] LVL_ONE   = {{(PWM_BITS-1){1'b0}}, 1'b1};
  localparam logic [PWM_BITS-1:0] CNT_LAST  = {{(PWM_BITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE_LOW, RAMP_UP, IDLE_HIGH, RAMP_DOWN} state_t;

  state_t              state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                pwm_q, pwm_d;
  logic                busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE_LOW;
      level_q   <= '0;
      duty_q    <= '0;
      pwm_cnt_q <= '0;
      step_q    <= '0;
      pwm_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_d;
      step_q    <= step_d;
      pwm_q     <= pwm_d;
      busy_q    <= busy_d;
    end
  end

  // A direction change is tested before the end-of-ramp and step checks so it wins on a shared edge.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    step_d  = step_q;
    if (!enable) begin
      state_d = IDLE_LOW;
      level_d = '0;
      step_d  = '0;
    end else begin
      case (state_q)
        IDLE_LOW: begin
          step_d = '0;
          if (blink_in) state_d = RAMP_UP;
        end
        RAMP_UP: begin
          if (!blink_in) begin
            state_d = RAMP_DOWN;
            step_d  = '0;
          end else if (level_q == LVL_MAX) begin
            state_d = IDLE_HIGH;
            step_d  = '0;
          end else if (step_q == STEP_LAST) begin
            step_d  = '0;
            level_d = level_q + LVL_ONE;
          end else begin
            step_d  = step_q + STEP_ONE;
          end
        end
        IDLE_HIGH: begin
          step_d = '0;
          if (!blink_in) state_d = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (blink_in) begin
            state_d = RAMP_UP;
            step_d  = '0;
          end else if (level_q == '0) begin
            state_d = IDLE_LOW;
            step_d  = '0;
          end else if (step_q == STEP_LAST) begin
            step_d  = '0;
            level_d = level_q - LVL_ONE;
          end else begin
            step_d  = step_q + STEP_ONE;
          end
        end
        default: begin
          state_d = IDLE_LOW;
          level_d = '0;
          step_d  = '0;
        end
      endcase
    end
    busy_d = (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
  end

  // Duty is only reloaded at the period wrap so a period never sees two compare values.
  always_comb begin
    pwm_cnt_d = (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + LVL_ONE;
    duty_d    = duty_q;
    if (!enable) begin
      duty_d = '0;
    end else if (pwm_cnt_q == CNT_LAST) begin
      duty_d = level_q;
    end
    pwm_d = enable && (pwm_cnt_q < duty_q);
  end

  assign pwm_out = pwm_q;
  assign level   = level_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// tb/tb_led_fade_pwm.sv - self-checking bench for led_fade_pwm (PWM_BITS=4, STEP_CYCLES=4)
module tb_led_fade_pwm;

  localparam int PB = 4;
  localparam int SC = 4;
  localparam int MX = 15;

  localparam int M_IL = 0;
  localparam int M_RU = 1;
  localparam int M_IH = 2;
  localparam int M_RD = 3;

  logic          clk;
  logic          rst_n;
  logic          blink_in;
  logic          enable;
  logic          pwm_out;
  logic [PB-1:0] level;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  led_fade_pwm #(.PWM_BITS(PB), .STEP_CYCLES(SC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .blink_in (blink_in),
    .enable   (enable),
    .pwm_out  (pwm_out),
    .level    (level),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model and duty scoreboard
  int  m_st, m_level, m_step, m_cnt, m_duty;
  bit  m_pwm, m_up, m_live, m_dirty;
  int  sb_q[$];
  int  hi_cnt;
  int  sb_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = M_IL; m_level = 0; m_step = 0; m_cnt = 0; m_duty = 0; m_pwm = 0; m_live = 0;
      sb_q.delete();
      sb_q.push_back(0);
    end else begin
      m_live = 1;
      m_pwm  = enable && (m_cnt < m_duty);
      if (!enable) m_duty = 0;
      else if (m_cnt == MX - 1) m_duty = m_level;
      if (m_cnt == MX - 1) begin
        sb_q.push_back(m_duty);
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      if (!enable) m_dirty = 1;

      if (!enable) begin
        m_st = M_IL; m_level = 0; m_step = 0;
      end else if (m_st == M_IL) begin
        if (blink_in) begin m_st = M_RU; m_step = 0; end
      end else if (m_st == M_IH) begin
        if (!blink_in) begin m_st = M_RD; m_step = 0; end
      end else begin
        m_up = (m_st == M_RU);
        if (blink_in != m_up) begin
          m_st = blink_in ? M_RU : M_RD; m_step = 0;
        end else if (m_level == (m_up ? MX : 0)) begin
          m_st = m_up ? M_IH : M_IL; m_step = 0;
        end else if (m_step == SC - 1) begin
          m_step = 0;
          m_level = m_up ? m_level + 1 : m_level - 1;
        end else begin
          m_step++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n || !m_live) begin
      hi_cnt = 0;
      m_dirty = 0;
    end else begin
      check("model_level", level, m_level);
      check("model_busy", busy, (m_st == M_RU || m_st == M_RD));
      check("model_pwm", pwm_out, m_pwm);
      hi_cnt += pwm_out;
      if (m_cnt == 0) begin
        if (sb_q.size() == 0) begin
          check("sb_not_empty", sb_q.size(), 1);
        end else begin
          sb_exp = sb_q.pop_front();
          if (!m_dirty) check("duty_count", hi_cnt, sb_exp);
        end
        hi_cnt = 0;
        m_dirty = 0;
      end
    end
  end

  task automatic reset_dut();
    blink_in = 1'b0;
    enable   = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_level(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (level == target) return;
    end
    check("wait_level_timeout", level, target);
  endtask

  typedef struct {
    logic blink;
    logic en;
    int   exp_level;
    logic exp_busy;
    logic exp_pwm;
    logic pwm_chk;
  } vec_t;

  vec_t vec[20];

  initial begin
    vec[0]  = '{1, 1, 0, 1, 0, 1};
    vec[1]  = '{0, 1, 0, 1, 0, 1};
    vec[2]  = '{0, 1, 0, 0, 0, 1};
    vec[3]  = '{0, 1, 0, 0, 0, 1};
    vec[4]  = '{1, 0, 0, 0, 0, 1};
    vec[5]  = '{1, 1, 0, 1, 0, 1};
    vec[6]  = '{1, 0, 0, 0, 0, 1};
    vec[7]  = '{0, 1, 0, 0, 0, 1};
    vec[8]  = '{1, 1, 0, 1, 0, 1};
    vec[9]  = '{1, 1, 0, 1, 0, 1};
    vec[10] = '{1, 1, 0, 1, 0, 1};
    vec[11] = '{1, 1, 0, 1, 0, 1};
    vec[12] = '{1, 1, 1, 1, 0, 1};
    vec[13] = '{0, 1, 1, 1, 0, 1};
    vec[14] = '{0, 1, 1, 1, 0, 0};
    vec[15] = '{0, 1, 1, 1, 0, 0};
    vec[16] = '{0, 1, 1, 1, 0, 0};
    vec[17] = '{0, 1, 0, 1, 0, 0};
    vec[18] = '{0, 1, 0, 0, 0, 0};
    vec[19] = '{0, 1, 0, 0, 0, 0};

    rst_n = 1'b0;
    blink_in = 1'b0;
    enable = 1'b1;
    reset_dut();
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_pwm", pwm_out, 0);

    // Short pulse, enable override and reversal at level 1
    for (int i = 0; i < 20; i++) begin
      blink_in = vec[i].blink;
      enable   = vec[i].en;
      @(negedge clk);
      check($sformatf("vec%0d_level", i), level, vec[i].exp_level);
      check($sformatf("vec%0d_busy", i), busy, vec[i].exp_busy);
      if (vec[i].pwm_chk) check($sformatf("vec%0d_pwm", i), pwm_out, vec[i].exp_pwm);
    end

    // Reset mid-ramp
    reset_dut();
    blink_in = 1'b1;
    wait_level(9, 100);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_pwm", pwm_out, 0);
    check("async_rst_level", level, 0);
    check("async_rst_busy", busy, 0);
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_level", level, 0);
      check("rst_hold_busy", busy, 0);
      check("rst_hold_pwm", pwm_out, 0);
    end
    blink_in = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_level", level, 0);
      check("post_rst_busy", busy, 0);
    end
    blink_in = 1'b1;
    @(negedge clk);
    check("post_rst_start_busy", busy, 1);

    // Full ramp up
    reset_dut();
    blink_in = 1'b1;
    for (int n = 0; n <= 60; n++) begin
      @(negedge clk);
      check($sformatf("ramp_up_e%0d_level", n), level, n / SC);
      check("ramp_up_busy", busy, 1);
    end
    @(negedge clk);
    check("idle_high_busy", busy, 0);
    check("idle_high_level", level, MX);
    repeat (30) @(negedge clk);
    for (int n = 0; n < MX; n++) begin
      @(negedge clk);
      check("full_duty_pwm", pwm_out, 1);
    end

    // Reversal at level 7
    reset_dut();
    blink_in = 1'b1;
    wait_level(7, 100);
    blink_in = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("rev_busy", busy, 1);
      check($sformatf("rev_k%0d_level", k), level, (k < 5) ? 7 : 6);
    end
    wait_level(0, 100);
    check("rev_at0_busy", busy, 1);
    @(negedge clk);
    check("rev_idle_busy", busy, 0);
    repeat (20) @(negedge clk);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      check("idle_low_pwm", pwm_out, 0);
    end

    // Enable drop at level 10
    reset_dut();
    blink_in = 1'b1;
    wait_level(10, 100);
    enable = 1'b0;
    @(negedge clk);
    check("en_drop_level", level, 0);
    check("en_drop_busy", busy, 0);
    check("en_drop_pwm", pwm_out, 0);
    enable = 1'b1;
    @(negedge clk);
    check("en_back_busy", busy, 1);
    check("en_back_level", level, 0);
    for (int k = 1; k <= SC; k++) begin
      @(negedge clk);
      check($sformatf("en_back_k%0d_level", k), level, (k < SC) ? 0 : 1);
    end

    // Repeated full ramps then random toggling for the duty scoreboard
    reset_dut();
    for (int r = 0; r < 3; r++) begin
      blink_in = 1'b1;
      repeat (80) @(negedge clk);
      blink_in = 1'b0;
      repeat (80) @(negedge clk);
    end
    for (int r = 0; r < 16; r++) begin
      blink_in = 1'($urandom_range(0, 1));
      repeat ($urandom_range(3, 40)) @(negedge clk);
    end
    blink_in = 1'b0;
    repeat (100) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
